// File: rtl/out_port_uart_tx.sv
// Buffers 16-bit CPU output words in a FIFO and sends each as two UART frames (low byte first).
// Optional macro UART_TX_PARITY_EN adds an even-parity bit per frame (8E1 instead of 8N1).
module out_port_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_AW      = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [15:0]        din,
   input  logic               din_valid,
   output logic               tx,
   output logic               busy,
   output logic               overflow,
   output logic [FIFO_AW:0]   fifo_level
);

   localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_LVL  = (FIFO_AW + 1)'(DEPTH);
   localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

   state_e             state_q, state_d;
   logic [BW-1:0]      baud_q, baud_d;
   logic [2:0]         bit_q, bit_d;
   logic               byte_sel_q, byte_sel_d;
   logic [15:0]        hold_q, hold_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;
   logic               overflow_q, overflow_d;
   logic [FIFO_AW:0]   level_q, level_d;
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [15:0]        mem_q [DEPTH];

   logic               pop;
   logic               push_ok;
   logic               baud_wrap;
   logic [7:0]         cur_byte;

   assign baud_wrap = (baud_q == BAUD_LAST);
   assign cur_byte  = byte_sel_q ? hold_q[15:8] : hold_q[7:0];

   // tx is registered, so each branch drives the level of the bit being entered.
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      byte_sel_d = byte_sel_q;
      hold_d     = hold_q;
      tx_d       = tx_q;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            baud_d = '0;
            if (level_q != '0) begin
               pop        = 1'b1;
               hold_d     = mem_q[rd_ptr_q];
               byte_sel_d = 1'b0;
               state_d    = START;
               tx_d       = 1'b0;
            end
         end
         START: begin
            baud_d = baud_q + BW'(1);
            if (baud_wrap) begin
               baud_d  = '0;
               bit_d   = 3'd0;
               state_d = DATA;
               tx_d    = cur_byte[0];
            end
         end
         DATA: begin
            baud_d = baud_q + BW'(1);
            if (baud_wrap) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = ^cur_byte;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = cur_byte[bit_q + 3'd1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            baud_d = baud_q + BW'(1);
            if (baud_wrap) begin
               baud_d  = '0;
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         STOP: begin
            baud_d = baud_q + BW'(1);
            if (baud_wrap) begin
               baud_d = '0;
               if (!byte_sel_q) begin
                  byte_sel_d = 1'b1;
                  state_d    = START;
                  tx_d       = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            baud_d  = '0;
         end
      endcase
   end

   // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
   always_comb begin
      push_ok    = din_valid && ((level_q != FULL_LVL) || pop);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q | (din_valid & ~push_ok);
      if (push_ok) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      if (push_ok && !pop)      level_d = level_q + (FIFO_AW + 1)'(1);
      else if (!push_ok && pop) level_d = level_q - (FIFO_AW + 1)'(1);
   end

   assign busy_d = (state_d != IDLE) || (level_d != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         byte_sel_q <= 1'b0;
         hold_q     <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
         level_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         byte_sel_q <= byte_sel_d;
         hold_q     <= hold_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         overflow_q <= overflow_d;
         level_q    <= level_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign overflow   = overflow_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Bench for out_port_uart_tx: directed scenarios plus random traffic against a timeline model
// of when each word occupies the line; honours UART_TX_PARITY_EN.
module tb_out_port_uart_tx;

   localparam int CPB   = 4;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int WORD = 2 * FB * CPB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [15:0]   din = '0;
   logic          din_valid = 1'b0;
   logic          tx;
   logic          busy;
   logic          overflow;
   logic [AW:0]   fifo_level;

   out_port_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .tx         (tx),
      .busy       (busy),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   // clock / reset block
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // scoreboard: accepted words and the edge at which each one is popped onto the line
   logic [15:0] exp_q[$];
   int          pop_q[$];
   int          last_pop = -100000;
   logic        exp_ovf = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic exp_tx(input int e);
      for (int i = 0; i < pop_q.size(); i++) begin
         if (e >= pop_q[i] && e < pop_q[i] + WORD) begin
            int o;
            int pos;
            logic [7:0] b;
            o   = (e - pop_q[i]) / CPB;
            pos = o % FB;
            b   = (o / FB != 0) ? exp_q[i][15:8] : exp_q[i][7:0];
            if (pos == 0) return 1'b0;
            if (pos <= 8) return b[pos-1];
            if (FB == 11 && pos == 9) return ^b;
            return 1'b1;
         end
      end
      return 1'b1;
   endfunction

   function automatic int exp_level(input int e);
      int n = 0;
      for (int i = 0; i < pop_q.size(); i++) if (pop_q[i] > e) n++;
      return n;
   endfunction

   function automatic logic exp_active(input int e);
      for (int i = 0; i < pop_q.size(); i++)
         if (e >= pop_q[i] && e < pop_q[i] + WORD) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_push(input int e, input logic [15:0] d);
      int p;
      if (exp_level(e) < DEPTH) begin
         p = (e + 1 > last_pop + WORD + 1) ? e + 1 : last_pop + WORD + 1;
         exp_q.push_back(d);
         pop_q.push_back(p);
         last_pop = p;
      end else begin
         exp_ovf = 1'b1;
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      pop_q.delete();
      last_pop = -100000;
      exp_ovf  = 1'b0;
   endtask

   task automatic check_outputs();
      int lvl;
      lvl = exp_level(cyc);
      check("tx", tx, exp_tx(cyc));
      check("fifo_level", fifo_level, lvl);
      check("busy", busy, (lvl != 0) || exp_active(cyc));
      check("overflow", overflow, exp_ovf);
   endtask

   // driver: one clock edge with optional push, outputs checked 1 time unit later
   task automatic step(input logic v, input logic [15:0] d);
      din       = d;
      din_valid = v;
      @(posedge clk);
      cyc++;
      if (v) model_push(cyc, d);
      while (pop_q.size() > 0 && pop_q[0] + WORD <= cyc) begin
         void'(pop_q.pop_front());
         void'(exp_q.pop_front());
      end
      #1;
      din_valid = 1'b0;
      check_outputs();
   endtask

   task automatic do_reset(input int hold);
      rst_n = 1'b0;
      #1;
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_level", fifo_level, 0);
      check("rst_overflow", overflow, 1'b0);
      model_clear();
      repeat (hold) begin
         @(posedge clk);
         cyc++;
      end
      #2;
      rst_n = 1'b1;
   endtask

   task automatic drain();
      int guard = 0;
      while (pop_q.size() > 0 && guard < 5000) begin
         step(1'b0, 16'h0);
         guard++;
      end
      check("drain_bound", guard < 5000, 1'b1);
      repeat (3) step(1'b0, 16'h0);
   endtask

   initial begin
      #2;
      // 1: reset
      do_reset(3);
      repeat (3) step(1'b0, 16'h0);

      // 2: single word, start bit one edge after the push
      step(1'b1, 16'hA55A);
      check("t2_idle_at_push", tx, 1'b1);
      step(1'b0, 16'h0);
      check("t2_start_low", tx, 1'b0);
      drain();
      check("t2_busy_done", busy, 1'b0);

      // 3: back-to-back words
      step(1'b1, 16'h0102);
      step(1'b1, 16'h0304);
      check("t3_level_peak", fifo_level, 1);
      drain();
      check("t3_no_overflow", overflow, 1'b0);

      // 4: overflow on the sixth consecutive push
      for (int i = 0; i < 6; i++) step(1'b1, 16'(i));
      check("t4_level_full", fifo_level, 4);
      check("t4_overflow", overflow, 1'b1);
      drain();
      check("t4_overflow_sticky", overflow, 1'b1);

      // 5: reset during DATA bit 3 of the low byte
      step(1'b1, 16'h1234);
      repeat (18) step(1'b0, 16'h0);
      do_reset(2);
      repeat (100) step(1'b0, 16'h0);
      check("t5_line_idle", tx, 1'b1);

      // 6: parity patterns (plain 8N1 frames when parity is disabled)
      step(1'b1, 16'h0003);
      drain();
      step(1'b1, 16'h0107);
      drain();

      // random traffic: isolated words with random gaps and occasional bursts
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            int len;
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++) step(1'b1, 16'($urandom));
         end else begin
            step(1'b1, 16'($urandom));
         end
         repeat ($urandom_range(0, 120)) step(1'b0, 16'h0);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
